// File: rtl/reg_bank_pkg.sv
// Shared definitions for the shift-capable register bank: mode encodings.
package reg_bank_pkg;

  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_HOLD = 2'b00;
  localparam logic [MODE_W-1:0] MODE_SHR  = 2'b01;
  localparam logic [MODE_W-1:0] MODE_SHL  = 2'b10;
  localparam logic [MODE_W-1:0] MODE_LOAD = 2'b11;

endpackage : reg_bank_pkg

// File: rtl/reg_bank_cell.sv
// One bank register: hold / shift right / shift left / parallel load, async clear.
module reg_bank_cell
  import reg_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upd,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  d,
  input  logic              ser_r,
  input  logic              ser_l,
  output logic [WIDTH-1:0]  q
);

  // Register update; shifted-out bits are discarded, not recirculated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (upd) begin
      case (mode)
        MODE_SHR:  q <= {ser_r, q[WIDTH-1:1]};
        MODE_SHL:  q <= {q[WIDTH-2:0], ser_l};
        MODE_LOAD: q <= d;
        default:   q <= q;
      endcase
    end
  end

endmodule : reg_bank_cell

// File: rtl/reg_bank_shift.sv
// Parametrised register bank with per-cycle addressed update and two
// combinational read ports plus a flat view of every register.
// Optional feature macro: REG_BANK_TRISTATE_EN adds active-low oe_n that
// floats q_a/q_b; q_all and register contents are unaffected by it.
module reg_bank_shift
  import reg_bank_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned SEL_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [SEL_W-1:0]          wr_sel,
  input  logic [MODE_W-1:0]         mode,
  input  logic [WIDTH-1:0]          d,
  input  logic                      ser_r,
  input  logic                      ser_l,
  input  logic [SEL_W-1:0]          rd_sel_a,
  input  logic [SEL_W-1:0]          rd_sel_b,
`ifdef REG_BANK_TRISTATE_EN
  input  logic                      oe_n,
`endif
  output logic [WIDTH-1:0]          q_a,
  output logic [WIDTH-1:0]          q_b,
  output logic [NUM_REGS*WIDTH-1:0] q_all
);

  logic [WIDTH-1:0]    regs [NUM_REGS];
  logic [NUM_REGS-1:0] upd;
  logic [WIDTH-1:0]    rd_a;
  logic [WIDTH-1:0]    rd_b;

  // Write decoder: an out-of-range wr_sel hits no cell and is dropped.
  always_comb begin
    upd = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (en && (wr_sel == SEL_W'(i))) upd[i] = 1'b1;
    end
  end

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_cell
    reg_bank_cell #(
      .WIDTH (WIDTH)
    ) u_cell (
      .clk   (clk),
      .rst   (rst),
      .upd   (upd[g]),
      .mode  (mode),
      .d     (d),
      .ser_r (ser_r),
      .ser_l (ser_l),
      .q     (regs[g])
    );
    assign q_all[g*WIDTH +: WIDTH] = regs[g];
  end

  // Read muxes: an out-of-range select reads as zero.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (rd_sel_a == SEL_W'(i)) rd_a = regs[i];
      if (rd_sel_b == SEL_W'(i)) rd_b = regs[i];
    end
  end

`ifdef REG_BANK_TRISTATE_EN
  assign q_a = oe_n ? 'z : rd_a;
  assign q_b = oe_n ? 'z : rd_b;
`else
  assign q_a = rd_a;
  assign q_b = rd_b;
`endif

endmodule : reg_bank_shift
